spi_flash_pp_ctrl: RTL and testbench
====================================

Name: spi_flash_pp_ctrl

Overview:
- Sequencer for one SPI-flash page program on an M25P16-class serial NOR device (SPI mode 0).
- Issues WREN (0x06), then PP (0x02) with a 24-bit address and 1..256 data bytes pulled from an upstream FIFO, then polls RDSR (0x05) until WIP clears.
- Sits between the user write logic/FIFO and the flash pins. It is the only master of cs_n/sck/mosi.

Parameters:
- SCK_HALF, 2, sys_clk cycles per SCK half-period (SCK = sys_clk/(2*SCK_HALF)); must be >= 1.
- CS_GAP, 5, sys_clk cycles cs_n is held high between commands (covers tSHSL).
- POLL_MAX, 16'd65535, maximum status bytes read before a timeout abort.

Ports:
- sys_clk, input, 1, system clock.
- sys_rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, one-cycle request; sampled only in IDLE.
- addr, input, 24, flash byte address; latched on an accepted start.
- len, input, 9, byte count 0..256; latched on an accepted start.
- data_req, output, 1, one-cycle pulse requesting the next data byte.
- wr_data, input, 8, data byte; must be valid the cycle after data_req (show-ahead-free FIFO timing).
- cs_n, output, 1, flash chip select.
- sck, output, 1, flash serial clock.
- mosi, output, 1, flash serial data in.
- miso, input, 1, flash serial data out.
- busy, output, 1, high from accepted start until done.
- done, output, 1, one-cycle completion pulse.
- err, output, 1, status of the last operation: 1 = poll timeout; cleared on the next accepted start.

Behaviour:
- Reset values: cs_n=1, sck=0, mosi=0, busy=0, done=0, err=0, data_req=0; FSM in IDLE. Reset is asynchronous and takes effect immediately mid-transfer. No resume after reset.
- Byte engine:
  - MSB first.
  - mosi updates while sck is low: the first bit is driven SCK_HALF cycles after cs_n falls, later bits on sck falling edges.
  - miso is sampled on sck rising edges.
  - 8 rising edges per byte; sck ends low.
  - cs_n is raised SCK_HALF cycles after the last falling edge.
- FSM states:
  - IDLE: start=1 and len!=0 -> latch addr/len, busy=1, err=0, go to WREN. start=1 and len==0 -> done pulses the next cycle, no pin activity, busy stays 0.
  - WREN: cs_n low, send 0x06, raise cs_n -> GAP.
  - GAP: count CS_GAP cycles with cs_n high, then go to the next command (PP_CMD after WREN; RDSR after PP).
  - PP_CMD: cs_n low, send 0x02 -> PP_ADDR.
  - PP_ADDR: send addr[23:16], addr[15:8], addr[7:0] -> PP_DATA.
  - PP_DATA:
    - data_req pulses once per byte, at least 2 cycles before that byte's first mosi bit.
    - wr_data is captured exactly 1 cycle after data_req.
    - Exactly len bytes are sent (len=256 -> 256 bytes), then cs_n is raised -> GAP.
  - RDSR:
    - cs_n low, send 0x05, then clock status bytes continuously with cs_n held low.
    - After each status byte: bit0==0 -> raise cs_n -> DONE.
    - Poll count reaching POLL_MAX -> raise cs_n, err=1 -> DONE.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- No page splitting. Bytes crossing a 256-byte page boundary wrap inside the page per flash behaviour. This is a caller responsibility, not checked.
- start while busy is ignored. A start coincident with the done cycle is ignored.
- Any miso value is accepted; only status bit0 is interpreted.
- Counters: bit count 3 bits, byte count 9 bits, poll count 16 bits. None wraps: each is compared against its limit before incrementing.

Test Plan:
- Reset then idle 100 cycles -> cs_n=1, sck=0, mosi=0, busy=0, done=0, no data_req.
- start with addr=24'h12_34_56, len=4, FIFO holding A0..A3, flash model WIP cleared after 3 polls. Required response:
  - mosi stream 06 | 02 12 34 56 A0 A1 A2 A3 | 05 + 3+ status bytes.
  - 3 cs_n low windows separated by >=CS_GAP cycles.
  - exactly 4 data_req pulses.
  - done=1 once, err=0.
- len=256 at addr=24'h00_01_00 -> 256 data_req pulses, 260 bytes in the PP window, flash page 0x000100..0x0001FF readback matches the input.
- len=0 -> done the next cycle, cs_n never low, busy never high.
- miso held high (WIP stuck) with POLL_MAX=4 -> exactly 4 status bytes after 0x05, then cs_n high, done=1, err=1.
- Assert sys_rst_n low mid-PP_ADDR, release, then start len=1 -> pins return to reset values asynchronously, and the second operation completes normally with the correct byte sequence.

Source files
------------

// File: rtl/spi_flash_pp_ctrl.sv
// Page-program sequencer for an M25P16-class SPI NOR flash (mode 0).
// Runs WREN, then PP with address and FIFO data, then polls RDSR until WIP clears.
module spi_flash_pp_ctrl #(
  parameter int          SCK_HALF = 2,
  parameter int          CS_GAP   = 5,
  parameter logic [15:0] POLL_MAX = 16'd65535
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        start,
  input  logic [23:0] addr,
  input  logic [8:0]  len,
  output logic        data_req,
  input  logic [7:0]  wr_data,
  output logic        cs_n,
  output logic        sck,
  output logic        mosi,
  input  logic        miso,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int HW = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
  localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WREN, S_GAP, S_PP_CMD, S_PP_ADDR, S_PP_DATA, S_RDSR, S_DONE
  } state_t;

  typedef enum logic [1:0] {PH_OFF, PH_LEAD, PH_RUN, PH_TAIL} phase_t;

  state_t      state, state_next;
  phase_t      phase;
  logic [HW-1:0] half_cnt;
  logic [GW-1:0] gap_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift_reg, data_hold;
  logic        rx_bit, cs_n_reg, sck_reg, mosi_reg;
  logic [23:0] addr_reg;
  logic [8:0]  len_reg, byte_cnt;
  logic [15:0] poll_cnt;
  logic        gap_to_rdsr, data_req_reg, data_req_d1, err_reg;

  logic        tick, rise, fall, byte_end, win_end, status_last;
  logic [8:0]  last_idx;
  logic        cmd_start, load, req_next, timeout, accept;
  logic [7:0]  cmd_byte, load_byte;

  assign tick        = (phase != PH_OFF) && (half_cnt == HW'(SCK_HALF - 1));
  assign rise        = (phase == PH_RUN) && !sck_reg && tick;
  assign fall        = (phase == PH_RUN) && sck_reg && tick;
  assign byte_end    = fall && (bit_cnt == 3'd7);
  assign win_end     = (phase == PH_TAIL) && tick;
  assign last_idx    = len_reg - 9'd1;
  assign status_last = (poll_cnt == POLL_MAX - 16'd1);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= S_IDLE;
    else            state <= state_next;
  end

  // At byte_end, load=1 continues the window with load_byte; load=0 closes it.
  always_comb begin
    state_next = state;
    cmd_start  = 1'b0;
    cmd_byte   = 8'h00;
    load       = 1'b0;
    load_byte  = 8'h00;
    req_next   = 1'b0;
    timeout    = 1'b0;
    accept     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          if (len != 9'd0) begin
            accept     = 1'b1;
            cmd_start  = 1'b1;
            cmd_byte   = 8'h06;
            state_next = S_WREN;
          end else begin
            state_next = S_DONE;
          end
        end
      end
      S_WREN: if (win_end) state_next = S_GAP;
      S_GAP: begin
        if (gap_cnt == GW'(CS_GAP - 1)) begin
          cmd_start  = 1'b1;
          cmd_byte   = gap_to_rdsr ? 8'h05 : 8'h02;
          state_next = gap_to_rdsr ? S_RDSR : S_PP_CMD;
        end
      end
      S_PP_CMD: begin
        if (byte_end) begin
          load       = 1'b1;
          load_byte  = addr_reg[23:16];
          state_next = S_PP_ADDR;
        end
      end
      S_PP_ADDR: begin
        // Request the first data byte three half-periods before it is needed.
        if (rise && bit_cnt == 3'd6 && byte_cnt == 9'd2) req_next = 1'b1;
        if (byte_end) begin
          load = 1'b1;
          if (byte_cnt == 9'd0)      load_byte = addr_reg[15:8];
          else if (byte_cnt == 9'd1) load_byte = addr_reg[7:0];
          else begin
            load_byte  = data_hold;
            state_next = S_PP_DATA;
          end
        end
      end
      S_PP_DATA: begin
        if (rise && bit_cnt == 3'd6 && byte_cnt != last_idx) req_next = 1'b1;
        if (byte_end && byte_cnt != last_idx) begin
          load      = 1'b1;
          load_byte = data_hold;
        end
        if (win_end) state_next = S_GAP;
      end
      S_RDSR: begin
        if (byte_end) begin
          if (byte_cnt == 9'd0)              load = 1'b1;
          else if (rx_bit && !status_last)   load = 1'b1;
          else if (rx_bit)                   timeout = 1'b1;
        end
        if (win_end) state_next = S_DONE;
      end
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      phase <= PH_OFF;       half_cnt <= '0;       gap_cnt <= '0;
      bit_cnt <= 3'd0;       shift_reg <= 8'h00;   data_hold <= 8'h00;
      rx_bit <= 1'b0;        cs_n_reg <= 1'b1;     sck_reg <= 1'b0;
      mosi_reg <= 1'b0;      addr_reg <= 24'h0;    len_reg <= 9'd0;
      byte_cnt <= 9'd0;      poll_cnt <= 16'd0;    gap_to_rdsr <= 1'b0;
      data_req_reg <= 1'b0;  data_req_d1 <= 1'b0;  err_reg <= 1'b0;
    end else begin
      data_req_reg <= req_next;
      data_req_d1  <= data_req_reg;
      if (data_req_d1) data_hold <= wr_data;
      if (accept) begin
        addr_reg    <= addr;
        len_reg     <= len;
        err_reg     <= 1'b0;
        gap_to_rdsr <= 1'b0;
      end
      if (timeout) err_reg <= 1'b1;
      if (state == S_PP_DATA && win_end) gap_to_rdsr <= 1'b1;
      if (state == S_GAP && gap_cnt != GW'(CS_GAP - 1)) gap_cnt <= gap_cnt + 1'b1;
      else                                              gap_cnt <= '0;

      if (cmd_start) begin
        byte_cnt <= 9'd0;
        poll_cnt <= 16'd0;
      end else if (byte_end && load) begin
        if (state == S_PP_CMD || (state == S_PP_ADDR && byte_cnt == 9'd2)) byte_cnt <= 9'd0;
        else if (state == S_RDSR && byte_cnt != 9'd0) poll_cnt <= poll_cnt + 16'd1;
        else byte_cnt <= byte_cnt + 9'd1;
      end

      // Bit engine: lead-in half period, 8 sck pulses per byte, tail half period.
      if (cmd_start) begin
        cs_n_reg  <= 1'b0;
        sck_reg   <= 1'b0;
        phase     <= PH_LEAD;
        half_cnt  <= '0;
        bit_cnt   <= 3'd0;
        shift_reg <= cmd_byte;
      end else if (phase != PH_OFF) begin
        half_cnt <= tick ? '0 : half_cnt + 1'b1;
        if (tick) begin
          unique case (phase)
            PH_LEAD: begin
              mosi_reg  <= shift_reg[7];
              shift_reg <= {shift_reg[6:0], 1'b0};
              phase     <= PH_RUN;
            end
            PH_RUN: begin
              if (!sck_reg) begin
                sck_reg <= 1'b1;
                rx_bit  <= miso;
              end else begin
                sck_reg <= 1'b0;
                if (bit_cnt != 3'd7) begin
                  bit_cnt   <= bit_cnt + 3'd1;
                  mosi_reg  <= shift_reg[7];
                  shift_reg <= {shift_reg[6:0], 1'b0};
                end else if (load) begin
                  bit_cnt   <= 3'd0;
                  mosi_reg  <= load_byte[7];
                  shift_reg <= {load_byte[6:0], 1'b0};
                end else begin
                  phase <= PH_TAIL;
                end
              end
            end
            PH_TAIL: begin
              cs_n_reg <= 1'b1;
              mosi_reg <= 1'b0;
              phase    <= PH_OFF;
            end
            default: phase <= PH_OFF;
          endcase
        end
      end
    end
  end

  assign cs_n     = cs_n_reg;
  assign sck      = sck_reg;
  assign mosi     = mosi_reg;
  assign data_req = data_req_reg;
  assign err      = err_reg;
  assign busy     = (state != S_IDLE) && (state != S_DONE);
  assign done     = (state == S_DONE);

endmodule

// File: tb/tb_spi_flash_pp_ctrl.sv
// Bench for spi_flash_pp_ctrl: pin-level flash/FIFO model, randomized page programs
// checked against expected command streams, counts and flash contents.
module tb_spi_flash_pp_ctrl;
  localparam int          SCK_HALF = 2;
  localparam int          CS_GAP   = 5;
  localparam logic [15:0] POLL_MAX = 16'd4;

  logic        sys_clk = 1'b0, sys_rst_n = 1'b0, start = 1'b0;
  logic [23:0] addr = 24'h0;
  logic [8:0]  len = 9'd0;
  logic [7:0]  wr_data = 8'h00;
  logic        data_req, cs_n, sck, mosi, miso, busy, done, err;

  int vectors = 0, miscompares = 0;

  always #5 sys_clk = ~sys_clk;

  spi_flash_pp_ctrl #(.SCK_HALF(SCK_HALF), .CS_GAP(CS_GAP), .POLL_MAX(POLL_MAX)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start), .addr(addr), .len(len),
    .data_req(data_req), .wr_data(wr_data), .cs_n(cs_n), .sck(sck), .mosi(mosi),
    .miso(miso), .busy(busy), .done(done), .err(err));

  // Flash / FIFO model state
  logic [7:0] fifo_q[$];
  logic [7:0] all_bytes[$];
  int         win_start[$], win_len[$], gaps[$];
  logic [7:0] fmem [int];
  int         wip_polls = 0, status_idx = 0;
  logic       wip = 1'b0, stuck = 1'b0;
  logic [7:0] sh = 8'h00;
  int         nbits = 0, pp_n = 0;
  logic [23:0] pp_a = 24'h0;
  int         req_cnt = 0, done_cnt = 0, busy_cnt = 0, hi_run = 0;

  assign miso = stuck | wip;

  // Registered FIFO read port: data appears the cycle after data_req.
  always @(posedge sys_clk) begin
    if (data_req && fifo_q.size() > 0) wr_data <= fifo_q.pop_front();
  end

  always @(posedge sys_clk) begin
    if (data_req) req_cnt++;
    if (done) done_cnt++;
    if (busy) busy_cnt++;
    if (cs_n === 1'b1) hi_run++;
    else begin
      if (hi_run > 0 && win_len.size() > 0) gaps.push_back(hi_run);
      hi_run = 0;
    end
  end

  always @(negedge cs_n) begin
    win_start.push_back(all_bytes.size());
    nbits = 0;
  end

  always @(posedge sck) begin
    if (cs_n === 1'b0 && win_start.size() > 0) begin
      sh = {sh[6:0], mosi};
      nbits++;
      if (nbits == 8) begin
        nbits = 0;
        all_bytes.push_back(sh);
        if (all_bytes[win_start[$]] == 8'h05 && all_bytes.size() - win_start[$] > 1) begin
          status_idx++;
          wip = (status_idx < wip_polls);
        end
      end
    end
  end

  // Page program commits on cs_n rise; address wraps inside the 256-byte page.
  always @(posedge cs_n) begin
    if (win_start.size() > win_len.size()) begin
      pp_n = all_bytes.size() - win_start[$];
      win_len.push_back(pp_n);
      if (pp_n >= 4 && all_bytes[win_start[$]] == 8'h02) begin
        pp_a = {all_bytes[win_start[$]+1], all_bytes[win_start[$]+2], all_bytes[win_start[$]+3]};
        for (int i = 4; i < pp_n; i++)
          fmem[int'({pp_a[23:8], 8'(pp_a[7:0] + 8'(i - 4))})] = all_bytes[win_start[$]+i];
        wip = (wip_polls > 0);
        status_idx = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    all_bytes.delete(); win_start.delete(); win_len.delete(); gaps.delete();
    req_cnt = 0; done_cnt = 0; busy_cnt = 0;
  endtask

  task automatic run_op(input logic [23:0] a, input int n, input int polls,
                        input logic exp_err, input bit fixed_data, input string tag);
    logic [7:0] data[$];
    logic [7:0] exp_q[$];
    int t, k;
    clear_logs();
    wip_polls = polls;
    for (int i = 0; i < n; i++) data.push_back(fixed_data ? 8'(8'hA0 + i) : 8'($urandom));
    fifo_q = data;
    @(negedge sys_clk); start = 1'b1; addr = a; len = 9'(n);
    @(negedge sys_clk); start = 1'b0;
    check($sformatf("%s busy_after_start", tag), busy, 1);
    check($sformatf("%s err_cleared", tag), err, 0);
    t = 0;
    while (done_cnt == 0 && t < 30000) begin @(negedge sys_clk); t++; end
    check($sformatf("%s done_within_bound", tag), done_cnt > 0, 1);
    repeat (3) @(negedge sys_clk);
    check($sformatf("%s done_count", tag), done_cnt, 1);
    check($sformatf("%s busy_after_done", tag), busy, 0);
    check($sformatf("%s err", tag), err, exp_err);
    check($sformatf("%s cs_n_idle", tag), cs_n, 1);
    check($sformatf("%s data_req_count", tag), req_cnt, n);
    check($sformatf("%s window_count", tag), win_len.size(), 3);
    if (win_len.size() == 3) begin
      check($sformatf("%s wren_len", tag), win_len[0], 1);
      check($sformatf("%s wren_byte", tag), all_bytes[win_start[0]], 8'h06);
      exp_q = {8'h02, a[23:16], a[15:8], a[7:0]};
      foreach (data[i]) exp_q.push_back(data[i]);
      check($sformatf("%s pp_len", tag), win_len[1], n + 4);
      for (int i = 0; i < n + 4; i++)
        if (i < win_len[1]) check($sformatf("%s pp_byte%0d", tag, i), all_bytes[win_start[1]+i], exp_q[i]);
      check($sformatf("%s rdsr_byte", tag), all_bytes[win_start[2]], 8'h05);
      check($sformatf("%s rdsr_len", tag), win_len[2], exp_err ? 1 + int'(POLL_MAX) : polls + 2);
    end
    check($sformatf("%s gap_count", tag), gaps.size(), 2);
    foreach (gaps[i]) check($sformatf("%s gap%0d_min", tag, i), gaps[i] >= CS_GAP, 1);
    for (int i = 0; i < n; i++) begin
      k = int'({a[23:8], 8'(a[7:0] + 8'(i))});
      check($sformatf("%s readback%0d", tag, i), fmem.exists(k) ? fmem[k] : 8'hzz, data[i]);
    end
  endtask

  initial begin
    int t;
    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    clear_logs();
    repeat (100) @(negedge sys_clk);
    check("rst cs_n", cs_n, 1);
    check("rst sck", sck, 0);
    check("rst mosi", mosi, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst err", err, 0);
    check("rst data_req_count", req_cnt, 0);
    check("rst windows", win_start.size(), 0);

    run_op(24'h123456, 4, 3, 1'b0, 1'b1, "basic");
    run_op(24'h000100, 256, int'($urandom_range(0, 3)), 1'b0, 1'b0, "page");

    // len == 0: done the next cycle, no pin activity, busy stays low
    clear_logs();
    @(negedge sys_clk); start = 1'b1; len = 9'd0; addr = 24'($urandom);
    @(negedge sys_clk); start = 1'b0;
    check("len0 done", done, 1);
    check("len0 busy", busy, 0);
    @(negedge sys_clk);
    check("len0 done_drop", done, 0);
    repeat (20) @(negedge sys_clk);
    check("len0 cs_windows", win_start.size(), 0);
    check("len0 busy_cycles", busy_cnt, 0);
    check("len0 done_count", done_cnt, 1);

    for (int r = 0; r < 3; r++)
      run_op(24'($urandom), int'($urandom_range(1, 20)), int'($urandom_range(0, 3)),
             1'b0, 1'b0, $sformatf("rand%0d", r));

    stuck = 1'b1;
    run_op(24'($urandom), int'($urandom_range(1, 6)), 0, 1'b1, 1'b0, "stuck");
    stuck = 1'b0;

    // Asynchronous reset in the middle of the address phase
    clear_logs();
    wip_polls = 0;
    fifo_q = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    @(negedge sys_clk); start = 1'b1; addr = 24'hABCDEF; len = 9'd5;
    @(negedge sys_clk); start = 1'b0;
    t = 0;
    while (all_bytes.size() < 3 && t < 5000) begin @(negedge sys_clk); t++; end
    check("rst_mid reached_pp_addr", all_bytes.size() >= 3, 1);
    #2 sys_rst_n = 1'b0;
    #1;
    check("rst_mid cs_n", cs_n, 1);
    check("rst_mid sck", sck, 0);
    check("rst_mid mosi", mosi, 0);
    check("rst_mid busy", busy, 0);
    check("rst_mid data_req", data_req, 0);
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    fifo_q.delete();
    repeat (10) @(negedge sys_clk);
    run_op(24'($urandom), 1, int'($urandom_range(0, 3)), 1'b0, 1'b0, "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
